mdu_unit: RTL and testbench

- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu over a fixed multi-cycle latency and holds the HI/LO architectural registers.
- Serves mfhi/mflo/mthi/mtlo.
- Produces the busy/stall-request signal that the hazard control unit consumes to freeze D-stage MD instructions while an operation is in flight.

---
 rtl/mdu_unit.sv | 158 +++++++++++++++
 tb/tb_mdu_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multiply/divide unit for the E stage: fixed-latency mult/div with HI/LO registers.
// Results are computed at the start edge and committed when the busy down-counter expires.
//
// state | meaning
// IDLE  | no operation in flight; accepts mult/div/mthi/mtlo
// RUN   | operation in flight; counter runs down, HI/LO commit at terminal count
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;

  logic        is_md;
  logic        mul_signed;
  logic        div_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] den_safe;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        div_zero;

  always_comb begin
    is_md = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
            (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
  end

  assign stall_req = busy | (start & is_md);

  always_comb begin
    rd_data = 32'd0;
    if (mdu_op == OP_MFHI)
      rd_data = hi;
    else if (mdu_op == OP_MFLO)
      rd_data = lo;
  end

  // 64x64 product of sign- or zero-extended operands; low 64 bits are exact for both
  always_comb begin
    mul_signed = (mdu_op == OP_MULT);
    mul_a      = {{32{mul_signed & rs_val[31]}}, rs_val};
    mul_b      = {{32{mul_signed & rt_val[31]}}, rt_val};
    prod       = mul_a * mul_b;
  end

  // Signed divide runs on magnitudes so 0x80000000 / -1 yields 0x80000000 without overflow
  always_comb begin
    div_signed = (mdu_op == OP_DIV);
    a_neg      = div_signed & rs_val[31];
    b_neg      = div_signed & rt_val[31];
    num        = a_neg ? (32'd0 - rs_val) : rs_val;
    den        = b_neg ? (32'd0 - rt_val) : rt_val;
    div_zero   = (rt_val == 32'd0);
    den_safe   = div_zero ? 32'd1 : den;
    quo_mag    = num / den_safe;
    rem_mag    = num % den_safe;
    quo        = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
    rem        = a_neg ? (32'd0 - rem_mag) : rem_mag;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= 4'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (mdu_op)
              OP_MULT, OP_MULTU: begin
                pend_hi <= prod[63:32];
                pend_lo <= prod[31:0];
                pend_wr <= 1'b1;
                cnt     <= MULT_LOAD;
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                pend_hi <= rem;
                pend_lo <= quo;
                pend_wr <= ~div_zero;
                cnt     <= DIV_LOAD;
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: driver pushes expected HI/LO and busy length per
// mult/div, a negedge monitor pops and compares whenever busy falls.
module tb_mdu_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mdu_op    (mdu_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo),
    .rd_data   (rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];
  int          len_q[$];

  // Architectural model: HI/LO as they will be once any in-flight op commits
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          busy_left = 0;

  logic rst_at_edge = 1'b0;
  always @(posedge clk) rst_at_edge <= reset;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_md(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  task automatic model_accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int              sa, sb;
    longint          la, lb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    logic [31:0]     eh, el;
    int              n;
    sa = a; sb = b; la = sa; lb = sb;
    ua = a; ub = b;
    eh = m_hi; el = m_lo; n = 0;
    case (op)
      4'd1: begin sp = la * lb; eh = sp[63:32]; el = sp[31:0]; n = MULT_N; end
      4'd2: begin up = ua * ub; eh = up[63:32]; el = up[31:0]; n = MULT_N; end
      4'd3: begin
        n = DIV_N;
        if (b != 32'd0) begin sq = la / lb; sr = la % lb; eh = sr[31:0]; el = sq[31:0]; end
      end
      4'd4: begin
        n = DIV_N;
        if (b != 32'd0) begin uq = ua / ub; ur = ua % ub; eh = ur[31:0]; el = uq[31:0]; end
      end
      4'd7: m_hi = a;
      4'd8: m_lo = a;
      default: ;
    endcase
    if (n != 0) begin
      exp_q.push_back({eh, el});
      len_q.push_back(n);
      m_hi = eh;
      m_lo = el;
      busy_left = n;
    end
  endtask

  task automatic step();
    logic        s;
    logic [3:0]  op;
    logic [31:0] a, b;
    s = start; op = mdu_op; a = rs_val; b = rt_val;
    @(posedge clk);
    if (!reset) begin
      busy_left = 0;
      m_hi = 32'd0;
      m_lo = 32'd0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (s) begin
      model_accept(op, a, b);
    end
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_rd;
    start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
    #1;
    chk("stall_req", stall_req, (busy_left > 0) || is_md(op));
    if (busy_left == 0) begin
      exp_rd = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
      chk("rd_data", rd_data, exp_rd);
    end
    step();
    start = 1'b0; mdu_op = 4'($urandom); rs_val = $urandom; rt_val = $urandom;
  endtask

  task automatic wait_idle();
    while (busy_left > 0) step();
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: a falling busy is either a commit or an abort by reset
  initial begin : monitor
    logic        prev;
    int          run;
    logic [63:0] e;
    int          n;
    prev = 1'b0;
    run  = 0;
    forever begin
      @(negedge clk);
      if (busy) begin
        run++;
      end else if (prev) begin
        if (!rst_at_edge) begin
          exp_q.delete();
          len_q.delete();
          chk("abort_hi", hi, 32'd0);
          chk("abort_lo", lo, 32'd0);
        end else if (exp_q.size() == 0) begin
          chk("commit_without_issue", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          n = len_q.pop_front();
          chk("commit_hi", hi, e[63:32]);
          chk("commit_lo", lo, e[31:0]);
          chk("busy_cycles", run, n);
        end
        run = 0;
      end
      prev = busy;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [3:0] op;
    reset = 1'b0; start = 1'b0; mdu_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
    repeat (2) step();
    chk("reset_busy", busy, 1'b0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_stall", stall_req, 1'b0);
    reset = 1'b1;
    step();

    // signed multiply
    issue(4'd1, 32'hFFFF_FFFD, 32'd5);
    chk("mult_busy", busy, 1'b1);
    wait_idle();
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    // unsigned divide and reads
    issue(4'd4, 32'd100, 32'd7);
    wait_idle();
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    issue(4'd6, 32'd0, 32'd0);
    issue(4'd5, 32'd0, 32'd0);

    // signed divide
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);

    // divide by zero, write while busy
    issue(4'd7, 32'h1234, 32'd0);
    issue(4'd8, 32'h5678, 32'd0);
    issue(4'd3, 32'd9, 32'd0);
    step();
    issue(4'd7, 32'hAAAA, 32'd0);
    wait_idle();
    chk("div0_hi", hi, 32'h1234);
    chk("div0_lo", lo, 32'h5678);

    // reset in third busy cycle
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    reset = 1'b1;
    repeat (15) step();
    chk("rst_no_commit_hi", hi, 32'd0);
    chk("rst_no_commit_lo", lo, 32'd0);

    // back-to-back
    issue(4'd1, 32'd2, 32'd3);
    wait_idle();
    chk("b2b_idle", busy, 1'b0);
    chk("b2b_hi", hi, 32'd0);
    chk("b2b_lo", lo, 32'd6);
    issue(4'd1, 32'd4, 32'd5);
    chk("b2b_accept", busy, 1'b1);
    wait_idle();
    issue(4'd6, 32'd0, 32'd0);

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 2)) step();
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(1, 4));
      issue(op, rand_word(), rand_word());
    end
    wait_idle();
    repeat (3) step();
    chk("final_hi", hi, m_hi);
    chk("final_lo", lo, m_lo);
    chk("queue_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
